// File: rtl/hw_sw_mailbox.sv
// Software/hardware handshake mailbox: a PIO batch is captured into a shadow bank
// and committed atomically to the active bank, either at capture or on frame sync.
module hw_sw_mailbox #(
    parameter int NUM_PORTS = 16,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [1:0]                  to_hw_sig,
    output logic [1:0]                  to_sw_sig,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in,
    input  logic                        commit_mode,
    input  logic                        frame_sync,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    output logic                        commit_pulse,
    output logic [CNT_W-1:0]            commit_count
);
    localparam int BANK_W = NUM_PORTS * DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        CLR_ACK = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BANK_W-1:0]   shadow_reg, shadow_next;
    logic [BANK_W-1:0]   active_reg, active_next;
    logic                pending_reg, pending_next;
    logic                pulse_reg, pulse_next;
    logic                fs_prev_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [1:0]          sw_reg, sw_next;

    logic fs_edge;
    logic req_xfer;
    logic req_clr;
    logic req_idle;

    assign fs_edge  = frame_sync & ~fs_prev_reg;
    assign req_xfer = (to_hw_sig == 2'b01);
    assign req_clr  = (to_hw_sig == 2'b11);
    // Codes 00 and 10 both mean idle, so bit 0 alone decides release.
    assign req_idle = ~to_hw_sig[0];

    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        count_next   = count_reg;
        pulse_next   = 1'b0;
        sw_next      = 2'b00;

        // Deferred commit can land in any state; a clear below overrides it.
        if (pending_reg && fs_edge) begin
            active_next  = shadow_reg;
            pending_next = 1'b0;
            count_next   = count_reg + CNT_W'(1);
            pulse_next   = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (req_clr) begin
                    shadow_next  = '0;
                    active_next  = '0;
                    pending_next = 1'b0;
                    count_next   = count_reg;
                    pulse_next   = 1'b0;
                    state_next   = CLR_ACK;
                end else if (req_xfer && !pending_reg) begin
                    shadow_next = port_in;
                    if (!commit_mode) begin
                        active_next = port_in;
                        count_next  = count_reg + CNT_W'(1);
                        pulse_next  = 1'b1;
                    end else begin
                        pending_next = 1'b1;
                    end
                    state_next = ACK;
                end
            end
            ACK: begin
                if (req_idle) state_next = IDLE;
            end
            CLR_ACK: begin
                if (req_idle) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            ACK:     sw_next = 2'b01;
            CLR_ACK: sw_next = 2'b11;
            default: sw_next = pending_next ? 2'b10 : 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            pulse_reg   <= 1'b0;
            fs_prev_reg <= 1'b0;
            count_reg   <= '0;
            sw_reg      <= 2'b00;
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            pulse_reg   <= pulse_next;
            fs_prev_reg <= frame_sync;
            count_reg   <= count_next;
            sw_reg      <= sw_next;
        end
    end

    assign port_out     = active_reg;
    assign commit_pulse = pulse_reg;
    assign commit_count = count_reg;
    assign to_sw_sig    = sw_reg;

endmodule

// File: tb/tb_hw_sw_mailbox.sv
// Scoreboard bench for hw_sw_mailbox: expected commits are queued when driven and
// matched against each commit_pulse; handshake codes are checked inline.
module tb_hw_sw_mailbox;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int PW = NP * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    to_hw_sig;
    logic [1:0]    to_sw_sig;
    logic [PW-1:0] port_in;
    logic          commit_mode;
    logic          frame_sync;
    logic [PW-1:0] port_out;
    logic          commit_pulse;
    logic [CW-1:0] commit_count;

    typedef struct {
        logic [PW-1:0] bank;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_cnt;
    logic [PW-1:0] exp_active;
    logic [PW-1:0] batch_a, batch_b;

    hw_sw_mailbox #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .to_hw_sig    (to_hw_sig),
        .to_sw_sig    (to_sw_sig),
        .port_in      (port_in),
        .commit_mode  (commit_mode),
        .frame_sync   (frame_sync),
        .port_out     (port_out),
        .commit_pulse (commit_pulse),
        .commit_count (commit_count)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_commit(input logic [PW-1:0] bank);
        exp_t e;
        exp_cnt    = exp_cnt + CW'(1);
        exp_active = bank;
        e.bank     = bank;
        e.cnt      = exp_cnt;
        exp_q.push_back(e);
    endtask

    function automatic logic [PW-1:0] rand_bank();
        logic [PW-1:0] b;
        for (int k = 0; k < NP; k++) b[k*DW +: DW] = $urandom;
        return b;
    endfunction

    task automatic async_reset();
        #4;
        reset_n = 1'b0;
        #1;
        check_val("rst_port_out", port_out, PW'(0));
        check_val("rst_to_sw", PW'(to_sw_sig), PW'(0));
        check_val("rst_count", PW'(commit_count), PW'(0));
        check_val("rst_pulse", PW'(commit_pulse), PW'(0));
        exp_cnt    = '0;
        exp_active = '0;
        to_hw_sig  = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_mode0(input logic [PW-1:0] bank);
        port_in     = bank;
        commit_mode = 1'b0;
        to_hw_sig   = 2'b01;
        push_commit(bank);
        tick();
        check_val("x_ack", PW'(to_sw_sig), PW'(2'b01));
        to_hw_sig = 2'b00;
        tick();
        check_val("x_release", PW'(to_sw_sig), PW'(2'b00));
    endtask

    // Every commit_pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && commit_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_pulse", PW'(commit_pulse), PW'(0));
            end else begin
                e = exp_q.pop_front();
                $display("commit: count=%0d port0=%08h", commit_count, port_out[31:0]);
                check_val("sb_bank", port_out, e.bank);
                check_val("sb_count", PW'(commit_count), PW'(e.cnt));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        to_hw_sig   = 2'b00;
        port_in     = '0;
        commit_mode = 1'b0;
        frame_sync  = 1'b0;
        exp_cnt     = '0;
        exp_active  = '0;
        batch_a     = '0;
        batch_b     = '0;
        #25;
        check_val("init_port_out", port_out, PW'(0));
        check_val("init_to_sw", PW'(to_sw_sig), PW'(0));
        check_val("init_count", PW'(commit_count), PW'(0));
        check_val("init_pulse", PW'(commit_pulse), PW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Mode 0: immediate commit
        for (int k = 0; k < NP; k++) port_in[k*DW +: DW] = DW'(k);
        port_in[3*DW +: DW] = 32'hDEADBEEF;
        commit_mode = 1'b0;
        to_hw_sig   = 2'b01;
        push_commit(port_in);
        tick();
        check_val("m0_port_out", port_out, exp_active);
        check_val("m0_port3", PW'(port_out[3*DW +: DW]), PW'(32'hDEADBEEF));
        check_val("m0_ack", PW'(to_sw_sig), PW'(2'b01));
        check_val("m0_pulse", PW'(commit_pulse), PW'(1));
        tick();
        check_val("m0_pulse_width", PW'(commit_pulse), PW'(0));
        check_val("m0_ack_hold", PW'(to_sw_sig), PW'(2'b01));
        repeat (3) tick();
        to_hw_sig = 2'b11;
        tick();
        check_val("m0_clr_ignored", PW'(to_sw_sig), PW'(2'b01));
        check_val("m0_clr_ign_data", port_out, exp_active);
        to_hw_sig = 2'b00;
        tick();
        check_val("m0_release", PW'(to_sw_sig), PW'(2'b00));
        check_val("m0_count", PW'(commit_count), PW'(1));

        // Mode 1: deferred commit on frame_sync rising edge
        for (int k = 0; k < NP; k++) port_in[k*DW +: DW] = 32'hA000_0000 + DW'(k);
        port_in[31:0] = 32'h12345678;
        batch_a     = port_in;
        commit_mode = 1'b1;
        to_hw_sig   = 2'b01;
        tick();
        check_val("m1_ack", PW'(to_sw_sig), PW'(2'b01));
        check_val("m1_hold", port_out, exp_active);
        port_in   = '1;
        to_hw_sig = 2'b00;
        tick();
        check_val("m1_busy", PW'(to_sw_sig), PW'(2'b10));
        repeat (2) tick();
        check_val("m1_busy_hold", PW'(to_sw_sig), PW'(2'b10));
        check_val("m1_no_change", port_out, exp_active);
        push_commit(batch_a);
        frame_sync = 1'b1;
        tick();
        check_val("m1_commit", port_out, exp_active);
        check_val("m1_port0", PW'(port_out[31:0]), PW'(32'h12345678));
        check_val("m1_idle", PW'(to_sw_sig), PW'(2'b00));
        frame_sync = 1'b0;
        tick();
        check_val("m1_pulse_width", PW'(commit_pulse), PW'(0));

        // Blocked request while a commit is pending
        batch_a   = rand_bank();
        port_in   = batch_a;
        to_hw_sig = 2'b01;
        tick();
        check_val("blk_ack1", PW'(to_sw_sig), PW'(2'b01));
        to_hw_sig = 2'b00;
        tick();
        check_val("blk_busy1", PW'(to_sw_sig), PW'(2'b10));
        batch_b   = rand_bank();
        port_in   = batch_b;
        to_hw_sig = 2'b01;
        repeat (2) tick();
        check_val("blk_no_ack", PW'(to_sw_sig), PW'(2'b10));
        check_val("blk_no_change", port_out, exp_active);
        push_commit(batch_a);
        frame_sync = 1'b1;
        tick();
        check_val("blk_commit_a", port_out, batch_a);
        check_val("blk_idle", PW'(to_sw_sig), PW'(2'b00));
        frame_sync = 1'b0;
        tick();
        check_val("blk_ack2", PW'(to_sw_sig), PW'(2'b01));
        check_val("blk_still_a", port_out, batch_a);
        to_hw_sig = 2'b00;
        tick();
        check_val("blk_busy2", PW'(to_sw_sig), PW'(2'b10));
        push_commit(batch_b);
        frame_sync = 1'b1;
        tick();
        check_val("blk_commit_b", port_out, batch_b);
        frame_sync = 1'b0;
        tick();

        // Clear while pending with a simultaneous fs_edge
        port_in   = rand_bank();
        to_hw_sig = 2'b01;
        tick();
        to_hw_sig = 2'b00;
        tick();
        check_val("clr_pending", PW'(to_sw_sig), PW'(2'b10));
        to_hw_sig  = 2'b11;
        frame_sync = 1'b1;
        tick();
        exp_active = '0;
        check_val("clr_zero", port_out, PW'(0));
        check_val("clr_ack", PW'(to_sw_sig), PW'(2'b11));
        check_val("clr_count", PW'(commit_count), PW'(exp_cnt));
        check_val("clr_no_pulse", PW'(commit_pulse), PW'(0));
        frame_sync = 1'b0;
        tick();
        check_val("clr_hold", PW'(to_sw_sig), PW'(2'b11));
        to_hw_sig = 2'b00;
        tick();
        check_val("clr_release", PW'(to_sw_sig), PW'(2'b00));
        frame_sync = 1'b1;
        tick();
        check_val("clr_no_commit", port_out, PW'(0));
        frame_sync = 1'b0;
        tick();

        // Asynchronous reset mid-ACK with a commit pending
        port_in   = rand_bank();
        to_hw_sig = 2'b01;
        tick();
        check_val("ar_ack", PW'(to_sw_sig), PW'(2'b01));
        async_reset();
        check_val("ar_idle", PW'(to_sw_sig), PW'(2'b00));
        do_mode0(rand_bank());
        check_val("ar_fresh_data", port_out, exp_active);
        check_val("ar_fresh_count", PW'(commit_count), PW'(1));

        // Counter wrap: 17 transfers from reset with a 4-bit counter
        async_reset();
        for (int i = 0; i < 17; i++) do_mode0(rand_bank());
        check_val("wrap_count", PW'(commit_count), PW'(1));
        check_val("wrap_data", port_out, exp_active);

        repeat (2) tick();
        check_val("sb_drained", PW'(exp_q.size()), PW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hw_sw_mailbox.md
# hw_sw_mailbox

- Parametrised handshake mailbox between the NIOS PIO ports and the game hardware.
- Software writes a batch of port values, then requests a transfer over a 2-bit signal pair.
- The block captures the whole batch into a shadow bank and acknowledges. It then commits the batch atomically to the active output bank, either immediately or on the next frame-sync edge, so the drawing logic never sees a half-written frame.
- Sits between `nios_system` PIO exports and the sprite/frame-drawing logic; replaces the fixed 16-port `hardware_software_comm`.

## Interface
Parameters:
- NUM_PORTS, 16, number of data ports (≥1)
- DATA_W, 32, bits per port
- CNT_W, 16, width of commit counter

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- to_hw_sig  in  2  request code from software: 00 idle, 01 transfer, 10 reserved (treated as 00), 11 clear
- to_sw_sig  out  2  status to software: 00 idle, 01 transfer ack, 10 busy (commit pending), 11 clear ack
- port_in  in  NUM_PORTS*DATA_W  PIO values; port k = [k*DATA_W +: DATA_W]
- commit_mode  in  1  0 = commit at capture, 1 = commit on next frame_sync rising edge
- frame_sync  in  1  frame-boundary level (e.g. inverted VGA_VS); rising edge detected internally
- port_out  out  NUM_PORTS*DATA_W  active bank, registered
- commit_pulse  out  1  high for exactly the cycle after active bank updates
- commit_count  out  CNT_W  number of commits since reset, wraps

## Operation
- State register values: IDLE, ACK, CLR_ACK. A separate `pending` flag is used in mode 1.
- All state, shadow bank, active bank, pending, commit_count and fs_prev are registered. Reset clears them all to 0, state to IDLE, to_sw_sig to 00.
- fs_edge = frame_sync & ~fs_prev; fs_prev is updated every cycle.
- IDLE, to_hw_sig==01, pending==0:
  - shadow <= port_in.
  - If commit_mode==0: active <= port_in on the same edge, commit_count++.
  - If commit_mode==1: pending <= 1.
  - Go to ACK.
- IDLE, to_hw_sig==01, pending==1: no capture; stay IDLE; request stays outstanding until pending clears.
- IDLE, to_hw_sig==11: shadow, active and pending are zeroed; go to CLR_ACK; commit_count unchanged.
- ACK: hold until to_hw_sig==00, then go to IDLE. A 01→11 change in ACK is ignored until 00 is seen.
- CLR_ACK: hold until to_hw_sig==00, then go to IDLE.
- Commit (mode 1): any cycle with pending==1 && fs_edge:
  - active <= shadow, pending <= 0, commit_count++.
  - Applies in any state.
- to_sw_sig (registered, from next state):
  - ACK → 01
  - CLR_ACK → 11
  - IDLE with pending → 10
  - otherwise 00
- commit_pulse is registered: high the cycle after any active-bank update from a commit. A clear does not raise it.
- commit_mode is sampled only at capture. A mode change while pending does not cancel the pending commit.

## Timing
- Request 01 sampled at edge N:
  - shadow is valid after N.
  - to_sw_sig==01 from N+1.
  - Mode 0: port_out valid after N; commit_pulse high during cycle N+1.
- Mode 1: port_out changes at the first edge where fs_edge==1 and pending==1. commit_pulse is high the following cycle.
- Release: to_hw_sig==00 sampled at edge M in ACK → to_sw_sig==00 (or 10 if pending) from M+1.
- Simultaneous cases:
  - fs_edge in the same cycle as a mode-1 capture (pending was 0): no commit. The new data waits for the next fs_edge; there is no same-cycle bypass.
  - fs_edge while pending, with a blocked 01: commit at that edge. Capture occurs at the next edge if 01 is still held and state is IDLE.
  - Clear (11) in IDLE while pending with fs_edge: clear wins. Active is zero, pending is 0, no commit_count increment.
- commit_count wraps from 2^CNT_W−1 to 0.
- Reset mid-transfer or mid-pending returns everything to reset values immediately (asynchronous). The first edge after release behaves as IDLE.

## Test plan
- Mode 0:
  - Stimulus: port_in port3=0xDEADBEEF, other ports = index; to_hw_sig 01 for 5 cycles, then 00.
  - Response: port_out port3=0xDEADBEEF one cycle after sampling; commit_pulse one cycle wide; to_sw_sig 01 then 00; commit_count=1.
- Mode 1 deferral:
  - Stimulus: capture 0x12345678 into port0; change port_in to 0xFFFFFFFF after ack.
  - Response: port_out unchanged and to_sw_sig==10 until the frame_sync rising edge; then port0=0x12345678 (not 0xFFFFFFFF); to_sw_sig returns to 00.
- Blocked request:
  - Stimulus: second 01 while pending.
  - Response: no ack until commit; after the fs_edge, the second batch is captured on the next edge and acked.
- Clear while pending with a simultaneous fs_edge:
  - Response: all port_out=0; to_sw_sig==11 until to_hw_sig==00; commit_count unchanged; no commit_pulse.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 mode-0 transfers.
  - Response: commit_count==1.
- Asynchronous reset:
  - Stimulus: assert reset_n=0 mid-ACK with pending=1.
  - Response: outputs zero immediately, without waiting for a clock edge; after release, a fresh 01 is captured normally.
